fetch_ctrl: RTL

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl_pkg.sv | 9 +
 rtl/fetch_ctrl.sv | 97 +++++++++
 2 files changed

// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg: shared fetch-controller defines (stall bus, stall bit indices, FSM states)
package fetch_ctrl_pkg;
  localparam int StallBus = 6;
  localparam logic Stop = 1'b1;
  localparam logic NoStop = 1'b0;
  localparam int stall_pc = 0;
  localparam int stall_ic = 1;
  typedef enum logic [2:0] {IDLE, REQ, WAIT, CANCEL, HOLD} state_t;
endpackage

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: single-outstanding instruction fetch FSM; ports: clk/rst, stall/flush/br_e pipeline control, pc_i/pc_valid fetch address, inst_req/inst_addr/inst_addr_ok/inst_data_ok/inst_rdata memory side, inst_o/pc_o/inst_valid_o/adel_o to IC stage, stallreq_if to pipeline controller
module fetch_ctrl
  import fetch_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [StallBus-1:0] stall,
  input  logic                flush,
  input  logic                br_e,
  input  logic [31:0]         pc_i,
  input  logic                pc_valid,
  output logic                inst_req,
  output logic [31:0]         inst_addr,
  input  logic                inst_addr_ok,
  input  logic                inst_data_ok,
  input  logic [31:0]         inst_rdata,
  output logic [31:0]         inst_o,
  output logic [31:0]         pc_o,
  output logic                inst_valid_o,
  output logic                adel_o,
  output logic                stallreq_if
);
  state_t state, state_n;
  logic kill, kill_q, kill_n, stop_ic, latch, buf_ld, fire, fire_adel;
  logic [31:0] addr_q, buf_q, fire_inst, fire_pc;
  logic unused;
  assign unused = &{1'b0, stall[StallBus-1:2]};
  assign kill = flush | br_e;
  assign stop_ic = stall[stall_ic] == Stop;
  assign inst_req = state == REQ;
  assign inst_addr = addr_q;
  assign stallreq_if = state inside {REQ, WAIT, CANCEL};
  always_comb begin
    state_n = state;
    kill_n = kill_q;
    latch = 1'b0;
    buf_ld = 1'b0;
    fire = 1'b0;
    fire_adel = 1'b0;
    fire_inst = '0;
    fire_pc = addr_q;
    case (state)
      IDLE: begin
        if (pc_valid && stall[stall_pc] == NoStop && !kill) begin
          latch = pc_i[1:0] == 2'b00;
          state_n = latch ? REQ : IDLE;
          fire = !latch;
          fire_adel = !latch;
          fire_pc = pc_i;
        end
      end
      REQ: begin
        kill_n = kill_q | kill;
        state_n = inst_addr_ok ? (kill_n ? CANCEL : WAIT) : REQ;
      end
      WAIT: begin
        state_n = inst_data_ok ? (!kill && stop_ic ? HOLD : IDLE) : (kill ? CANCEL : WAIT);
        fire = inst_data_ok && !kill && !stop_ic;
        buf_ld = inst_data_ok && !kill && stop_ic;
        fire_inst = inst_rdata;
      end
      CANCEL: begin
        state_n = inst_data_ok ? IDLE : CANCEL;
        kill_n = inst_data_ok ? 1'b0 : kill_q;
      end
      HOLD: begin
        state_n = kill || !stop_ic ? IDLE : HOLD;
        fire = !kill && !stop_ic;
        fire_inst = buf_q;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      kill_q <= 1'b0;
      addr_q <= '0;
      buf_q <= '0;
      inst_o <= '0;
      pc_o <= '0;
      inst_valid_o <= 1'b0;
      adel_o <= 1'b0;
    end else begin
      state <= state_n;
      kill_q <= kill_n;
      inst_valid_o <= fire;
      adel_o <= fire_adel;
      if (latch) addr_q <= pc_i;
      if (buf_ld) buf_q <= inst_rdata;
      if (fire) begin
        inst_o <= fire_inst;
        pc_o <= fire_pc;
      end
    end
  end
endmodule
